// File: rtl/seq_mul16.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : seq_mul16
//  Purpose  : Multi-cycle unsigned shift-and-add multiplier. Performs one
//             conditional add of the multiplicand per clock and delivers a
//             2*WIDTH-bit product. Valid/ready handshakes on both sides let
//             a sequencer stall on it.
//  Ports    : clk        - system clock, rising edge active
//             rst_n      - asynchronous active-low reset
//             in_valid   - operand pair valid
//             in_ready   - block can accept operands (IDLE)
//             a, b       - multiplicand / multiplier, unsigned, WIDTH bits
//             out_valid  - product valid (DONE)
//             out_ready  - consumer accepts product
//             out_hi     - product bits [2*WIDTH-1:WIDTH]
//             out_lo     - product bits [WIDTH-1:0]
//             out_ovf    - product does not fit in WIDTH bits
//             busy       - multiplication in progress (BUSY)
//  Revision : 1.0 - initial release
// ============================================================================
module seq_mul16 #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5    // 2**CNT_W must exceed WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_hi,
   output logic [WIDTH-1:0] out_lo,
   output logic             out_ovf,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   hi_q,    hi_d;
   logic [WIDTH-1:0]   lo_q,    lo_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;

   // One extra bit so the adder carry survives into hi[WIDTH-1] after the shift.
   logic [WIDTH:0]     w_sum;

   assign w_sum = lo_q[0] ? ({1'b0, hi_q} + {1'b0, mcand_q}) : {1'b0, hi_q};

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath update
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mcand_d = a;
               lo_d    = b;
               hi_d    = '0;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end

         S_BUSY: begin
            // {hi, lo} <= {carry, sum, lo} >> 1 : multiplier bits retire from
            // the bottom of lo while product bits enter from the top.
            hi_d  = w_sum[WIDTH:1];
            lo_d  = {w_sum[0], lo_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_LAST_STEP) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            // Release goes through IDLE, so a new accept is always one edge later.
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs: decoded from state or taken straight from the registers, so an
   // asynchronous reset clears them without waiting for a clock edge.
   // ------------------------------------------------------------------------
   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_BUSY);
   assign out_valid = (state_q == S_DONE);
   assign out_hi    = hi_q;
   assign out_lo    = lo_q;
   assign out_ovf   = |hi_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul16.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_seq_mul16
//  Purpose  : Self-checking bench for seq_mul16. Table of directed operand
//             pairs with hand-computed products, plus hand-written sequences
//             for backpressure, asynchronous reset and back-to-back streaming.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mul16;

   localparam int WIDTH = 16;
   localparam int CNT_W = 5;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_hi;
   logic [WIDTH-1:0] out_lo;
   logic             out_ovf;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   seq_mul16 #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_hi    (out_hi),
      .out_lo    (out_lo),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] va;
      logic [15:0] vb;
      logic [31:0] prod;
      logic        ovf;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      chk({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   // Accept one operand pair, measure latency, check product, hand it off.
   task automatic do_mul(input logic [15:0] va, input logic [15:0] vb,
                         input logic [31:0] prod, input logic ovf, input string name);
      int lat;
      wait_ready(name);
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      tick();                                   // accept edge E
      in_valid = 1'b0;
      chk({name, " busy"}, {31'd0, busy}, 32'd1);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk({name, " latency"}, lat, 32'd16);
      chk({name, " product"}, {out_hi, out_lo}, prod);
      chk({name, " ovf"}, {31'd0, out_ovf}, {31'd0, ovf});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({name, " released"}, {30'd0, out_valid, in_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int cyc;
      int idx_in;
      int idx_out;
      int t_prev;
      logic prev_ready;
      logic saw_valid;
      logic [31:0] stream_exp [3];
      logic [15:0] stream_a [3];
      logic [15:0] stream_b [3];

      vecs[0]  = '{16'h0003, 16'h0005, 32'h0000_000F, 1'b0};
      vecs[1]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1};
      vecs[2]  = '{16'h8000, 16'h0002, 32'h0001_0000, 1'b1};
      vecs[3]  = '{16'h0000, 16'hFFFF, 32'h0000_0000, 1'b0};
      vecs[4]  = '{16'hFFFF, 16'h0000, 32'h0000_0000, 1'b0};
      vecs[5]  = '{16'h00FF, 16'h0101, 32'h0000_FFFF, 1'b0};
      vecs[6]  = '{16'h0100, 16'h0100, 32'h0001_0000, 1'b1};
      vecs[7]  = '{16'hFFFF, 16'h0001, 32'h0000_FFFF, 1'b0};
      vecs[8]  = '{16'h1234, 16'h0010, 32'h0001_2340, 1'b1};
      vecs[9]  = '{16'h1111, 16'h2222, 32'h0246_8642, 1'b1};
      vecs[10] = '{16'h0001, 16'h8000, 32'h0000_8000, 1'b0};
      vecs[11] = '{16'h0007, 16'h0006, 32'h0000_002A, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;

      // Reset state
      #12;
      chk("reset ready/busy/valid", {29'd0, in_ready, busy, out_valid}, 32'h4);
      chk("reset product", {out_hi, out_lo}, 32'd0);
      chk("reset ovf", {31'd0, out_ovf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Directed table
      for (int i = 0; i < 12; i++) begin
         do_mul(vecs[i].va, vecs[i].vb, vecs[i].prod, vecs[i].ovf, $sformatf("vec%0d", i));
      end

      // Backpressure: hold out_ready low with new operands presented
      wait_ready("bp");
      a        = 16'h0005;
      b        = 16'h0009;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("bp latency", cyc, 32'd16);
      a        = 16'h1111;
      b        = 16'h2222;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("bp hold%0d flags", i), {30'd0, out_valid, in_ready}, 32'h2);
         chk($sformatf("bp hold%0d product", i), {out_hi, out_lo}, 32'h0000_002D);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp release to idle", {30'd0, out_valid, in_ready}, 32'h1);
      tick();                                   // accept of held operands
      in_valid = 1'b0;
      chk("bp accept busy", {31'd0, busy}, 32'd1);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("bp2 latency", cyc, 32'd16);
      chk("bp2 product", {out_hi, out_lo}, 32'h0246_8642);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Asynchronous reset after 8 BUSY edges
      wait_ready("arst");
      a        = 16'hFFFF;
      b        = 16'hFFFF;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("arst pre busy", {31'd0, busy}, 32'd1);
      #1;
      rst_n = 1'b0;                             // mid-cycle, no clock edge nearby
      #1;
      chk("arst flags", {29'd0, in_ready, busy, out_valid}, 32'h4);
      chk("arst product", {out_hi, out_lo}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      saw_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid) saw_valid = 1'b1;
      end
      chk("arst no stale valid", {31'd0, saw_valid}, 32'd0);
      do_mul(16'h0007, 16'h0006, 32'h0000_002A, 1'b0, "post-arst");

      // Back-to-back streaming with in_valid and out_ready held high
      stream_a[0] = 16'h0001; stream_b[0] = 16'h0001; stream_exp[0] = 32'h0000_0001;
      stream_a[1] = 16'h1234; stream_b[1] = 16'h0010; stream_exp[1] = 32'h0001_2340;
      stream_a[2] = 16'hFFFF; stream_b[2] = 16'h0002; stream_exp[2] = 32'h0001_FFFE;
      wait_ready("b2b");
      idx_in    = 0;
      idx_out   = 0;
      t_prev    = 0;
      a         = stream_a[0];
      b         = stream_b[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      cyc       = 0;
      while (idx_out < 3 && cyc < 100) begin
         prev_ready = in_ready;
         tick();
         cyc++;
         if (prev_ready && in_valid) begin
            idx_in++;
            if (idx_in < 3) begin
               a = stream_a[idx_in];
               b = stream_b[idx_in];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            chk($sformatf("b2b result%0d", idx_out), {out_hi, out_lo}, stream_exp[idx_out]);
            if (idx_out > 0) begin
               chk($sformatf("b2b spacing%0d", idx_out), cyc - t_prev, 32'd18);
            end
            t_prev = cyc;
            idx_out++;
         end
      end
      chk("b2b completed", idx_out, 32'd3);
      in_valid  = 1'b0;
      out_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_mul16.md
Name: seq_mul16

Overview:
Multi-cycle unsigned shift-and-add multiplier that consumes the 16-bit ripple adder datapath. It performs one conditional add per clock and produces a 32-bit product.
- Sits downstream of the 16-bit adder stage.
- Feeds the ALU-extension result mux.
- Uses a valid/ready handshake on both sides so a CPU sequencer can stall on it.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH bits.
CNT_W, 5, step-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand, unsigned
b  input  WIDTH  multiplier, unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
out_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]
out_lo  output  WIDTH  product bits [WIDTH-1:0]
out_ovf  output  1  1 when out_hi != 0, i.e. the product does not fit in WIDTH bits
busy  output  1  1 in BUSY state

Behaviour:
- One clock, clk. Reset is asynchronous and active-low: rst_n low forces state immediately, regardless of clk.
- Reset values:
  - state = IDLE.
  - mcand, hi, lo, cnt = 0.
  - out_valid = 0, busy = 0, out_hi = out_lo = 0, out_ovf = 0.
  - in_ready = 1, since it is decoded from state IDLE.
- States and transitions:
  - IDLE: in_ready = 1. On an edge with in_valid && in_ready: mcand <= a, lo <= b, hi <= 0, cnt <= 0, go to BUSY.
  - BUSY: in_ready = 0, busy = 1. Each edge:
    - {c, s} = lo[0] ? hi + mcand : {0, hi}, a WIDTH+1-bit sum with carry out c.
    - {hi, lo} <= {c, s, lo} >> 1.
    - cnt <= cnt + 1.
    - On the edge where cnt == WIDTH-1, go to DONE.
  - DONE: out_valid = 1; {out_hi, out_lo} = {hi, lo}; in_ready = 0. On an edge with out_ready = 1, go to IDLE.
- Latency: the accept edge is E. Exactly WIDTH BUSY edges follow, so out_valid rises after edge E+WIDTH.
- Throughput: with out_ready and in_valid held at 1, one result every WIDTH+2 cycles.
- The carry out of the adder must be retained into hi[WIDTH-1]; a dropped carry is a bug.
- out_hi, out_lo and out_ovf are driven from the internal registers at all times. They are only meaningful while out_valid = 1, and must be stable for the whole of DONE.
- No same-cycle output-release and input-accept: a new operand is accepted only in IDLE, one edge after the DONE handshake.
- in_valid asserted in BUSY or DONE is ignored. The source must hold a and b until it sees in_ready.
- rst_n asserted mid-BUSY or mid-DONE:
  - The in-flight operation is discarded and the outputs return to reset values immediately.
  - No out_valid pulse is produced for the discarded operation.
- Operand edge cases:
  - a = 0 or b = 0 gives product 0 and ovf = 0, with unchanged latency.
  - All-ones operands must not wrap.

Test Plan:
1. Reset release, then a=3, b=5 with in_valid for one cycle -> out_valid rises exactly 16 edges after accept; out_lo=0x000F, out_hi=0x0000, out_ovf=0.
2. a=0xFFFF, b=0xFFFF -> out_hi=0xFFFE, out_lo=0x0001, out_ovf=1; this exercises the carry on every step.
3. a=0x8000, b=0x0002 -> out_hi=0x0001, out_lo=0x0000, out_ovf=1. Then a=0, b=0xFFFF -> 0x0000/0x0000, ovf=0, same latency.
4. Backpressure: out_ready=0 for 5 cycles after out_valid with in_valid=1 and new operands present -> outputs unchanged, in_ready=0, no operand accepted. When out_ready=1 -> IDLE next edge, then accept.
5. Pull rst_n low asynchronously (mid-cycle) after 8 BUSY edges -> busy=0, in_ready=1 and out_valid=0 without waiting for a clock edge. After release, a=7, b=6 -> out_lo=0x002A, out_hi=0.
6. Back-to-back: in_valid=1 and out_ready=1 held, operand stream (1,1), (0x1234,0x0010), (0xFFFF,2) -> results 0x00000001, 0x00012340, 0x0001FFFE. out_valid pulses spaced 18 cycles apart.
